// File: rtl/sdram_pkg.sv
// Shared SDR SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// the precharge-all address constant and the refresh FSM state type.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PREC = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  // A10 high selects all banks for PRECHARGE; zero-extend to the bus width.
  localparam logic [10:0] ADDR_PALL = 11'h400;

  typedef enum logic [2:0] {
    AREF_IDLE,
    AREF_PREC,
    AREF_WAIT_RP,
    AREF_AREF,
    AREF_WAIT_RFC,
    AREF_DONE
  } aref_state_t;

endpackage

// File: rtl/sdram_aref_timer.sv
// Refresh-debt bookkeeping: free-running tREFI interval counter, tick, and
// saturating debt counter decremented once per AREF issued by the FSM.
// Ports: sclk, srst (async, active high), dec (AREF this cycle),
//        tick (interval end this cycle), debt (outstanding refreshes).
// With SDRAM_AREF_STATS_EN defined: aref_total (AREFs issued, wrapping)
//        and aref_drop (sticky, a tick arrived while debt was saturated).
module sdram_aref_timer
  import sdram_pkg::*;
#(
  parameter int unsigned TREFI    = 750,
  parameter int unsigned MAX_DEBT = 8,
  parameter int unsigned DEBT_W   = $clog2(MAX_DEBT + 1)
) (
  input  logic              sclk,
  input  logic              srst,
  input  logic              dec,
  output logic              tick,
`ifdef SDRAM_AREF_STATS_EN
  output logic [15:0]       aref_total,
  output logic              aref_drop,
`endif
  output logic [DEBT_W-1:0] debt
);

  localparam int unsigned IVL_W = (TREFI > 2) ? $clog2(TREFI) : 1;

  logic [IVL_W-1:0] ivl_cnt;
  logic             at_max;

  assign tick   = (ivl_cnt == IVL_W'(TREFI - 1));
  assign at_max = (debt == DEBT_W'(MAX_DEBT));

  // Interval counter keeps running through bursts.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      ivl_cnt <= '0;
    end else if (tick) begin
      ivl_cnt <= '0;
    end else begin
      ivl_cnt <= ivl_cnt + IVL_W'(1);
    end
  end

  // Tick and AREF together cancel; a tick at saturation is lost.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      debt <= '0;
    end else if (tick && !dec && !at_max) begin
      debt <= debt + DEBT_W'(1);
    end else if (dec && !tick) begin
      debt <= debt - DEBT_W'(1);
    end
  end

`ifdef SDRAM_AREF_STATS_EN
  // Refresh statistics.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      aref_total <= '0;
      aref_drop  <= 1'b0;
    end else begin
      if (dec) begin
        aref_total <= aref_total + 16'd1;
      end
      if (tick && at_max && !dec) begin
        aref_drop <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sdram_aref_ctrl.sv
// Auto-refresh engine: requests the arbiter when refresh debt is owed, then on
// grant issues PRECHARGE-all and a burst of up to BURST AUTO REFRESH commands
// spaced by tRP / tRFC.
// Ports: sclk, srst (async, active high), aref_en (arbiter grant, held for
//        the whole burst), sdram_cmd {cs_n,ras_n,cas_n,we_n}, sdram_addr
//        (A10 only, constant), flag_aref_ask, flag_aref_urgent,
//        flag_aref_end (one-cycle burst-complete pulse).
// Optional macro SDRAM_AREF_STATS_EN adds aref_total[15:0] and aref_drop.
module sdram_aref_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned TREFI     = 750,
  parameter int unsigned TRP       = 2,
  parameter int unsigned TRFC      = 7,
  parameter int unsigned BURST     = 2,
  parameter int unsigned MAX_DEBT  = 8,
  parameter int unsigned URGENT_TH = 4
) (
  input  logic              sclk,
  input  logic              srst,
  input  logic              aref_en,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
`ifdef SDRAM_AREF_STATS_EN
  output logic [15:0]       aref_total,
  output logic              aref_drop,
`endif
  output logic              flag_aref_ask,
  output logic              flag_aref_urgent,
  output logic              flag_aref_end
);

  localparam int unsigned DEBT_W  = $clog2(MAX_DEBT + 1);
  localparam int unsigned TMR_MAX = (TRP > TRFC) ? TRP : TRFC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned BCNT_W  = $clog2(BURST + 1);

  aref_state_t       state;
  logic [TMR_W-1:0]  tmr;
  logic [BCNT_W-1:0] burst_cnt;
  logic [DEBT_W-1:0] debt;
  logic              tick;
  logic              dec;
  logic              more_rfc;
  logic              more_aref;

  assign dec        = (state == AREF_AREF);
  assign sdram_addr = ADDR_W'(ADDR_PALL);

  assign flag_aref_ask    = (state == AREF_IDLE) && (debt != '0);
  assign flag_aref_urgent = (debt >= DEBT_W'(URGENT_TH));

  // Continue decision from WAIT_RFC: debt here already reflects the last AREF,
  // and a tick landing on this edge still counts.
  assign more_rfc  = (burst_cnt < BCNT_W'(BURST)) && ((debt != '0) || tick);
  // Same decision taken directly from AREF when tRFC is a single cycle.
  assign more_aref = ((burst_cnt + BCNT_W'(1)) < BCNT_W'(BURST)) &&
                     ((debt > DEBT_W'(1)) || tick);

  sdram_aref_timer #(
    .TREFI    (TREFI),
    .MAX_DEBT (MAX_DEBT),
    .DEBT_W   (DEBT_W)
  ) u_timer (
    .sclk       (sclk),
    .srst       (srst),
    .dec        (dec),
    .tick       (tick),
`ifdef SDRAM_AREF_STATS_EN
    .aref_total (aref_total),
    .aref_drop  (aref_drop),
`endif
    .debt       (debt)
  );

  // Refresh FSM; sdram_cmd and flag_aref_end are registered alongside the
  // state so they always match the state being entered.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      state         <= AREF_IDLE;
      tmr           <= '0;
      burst_cnt     <= '0;
      sdram_cmd     <= CMD_NOP;
      flag_aref_end <= 1'b0;
    end else begin
      sdram_cmd     <= CMD_NOP;
      flag_aref_end <= 1'b0;
      case (state)
        AREF_IDLE: begin
          if (aref_en && (debt != '0)) begin
            state     <= AREF_PREC;
            sdram_cmd <= CMD_PREC;
          end
        end
        AREF_PREC: begin
          if (TRP == 1) begin
            state     <= AREF_AREF;
            sdram_cmd <= CMD_AREF;
          end else begin
            state <= AREF_WAIT_RP;
            tmr   <= TMR_W'(TRP - 1);
          end
        end
        AREF_WAIT_RP: begin
          // tmr reaches 0 on the edge that leaves this state.
          if (tmr == TMR_W'(1)) begin
            tmr       <= '0;
            state     <= AREF_AREF;
            sdram_cmd <= CMD_AREF;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        AREF_AREF: begin
          burst_cnt <= burst_cnt + BCNT_W'(1);
          if (TRFC == 1) begin
            if (more_aref) begin
              state     <= AREF_AREF;
              sdram_cmd <= CMD_AREF;
            end else begin
              state         <= AREF_DONE;
              flag_aref_end <= 1'b1;
            end
          end else begin
            state <= AREF_WAIT_RFC;
            tmr   <= TMR_W'(TRFC - 1);
          end
        end
        AREF_WAIT_RFC: begin
          if (tmr == TMR_W'(1)) begin
            tmr <= '0;
            if (more_rfc) begin
              state     <= AREF_AREF;
              sdram_cmd <= CMD_AREF;
            end else begin
              state         <= AREF_DONE;
              flag_aref_end <= 1'b1;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        AREF_DONE: begin
          burst_cnt <= '0;
          state     <= AREF_IDLE;
        end
        default: begin
          state <= AREF_IDLE;
        end
      endcase
    end
  end

endmodule
